// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, ALU and condition
// function codes, status codes, register ids and the pipeline-bubble field values.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IcodeHalt   = 4'd0;
  localparam logic [3:0] IcodeNop    = 4'd1;
  localparam logic [3:0] IcodeRrmovq = 4'd2;
  localparam logic [3:0] IcodeIrmovq = 4'd3;
  localparam logic [3:0] IcodeRmmovq = 4'd4;
  localparam logic [3:0] IcodeMrmovq = 4'd5;
  localparam logic [3:0] IcodeOpq    = 4'd6;
  localparam logic [3:0] IcodeJxx    = 4'd7;
  localparam logic [3:0] IcodeCall   = 4'd8;
  localparam logic [3:0] IcodeRet    = 4'd9;
  localparam logic [3:0] IcodePushq  = 4'd10;
  localparam logic [3:0] IcodePopq   = 4'd11;

  // ALU functions (OPQ ifun)
  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluXor = 4'd3;

  // Condition functions (jXX / cmovXX ifun)
  localparam logic [3:0] CondAlways = 4'd0;
  localparam logic [3:0] CondLe     = 4'd1;
  localparam logic [3:0] CondL      = 4'd2;
  localparam logic [3:0] CondE      = 4'd3;
  localparam logic [3:0] CondNe     = 4'd4;
  localparam logic [3:0] CondGe     = 4'd5;
  localparam logic [3:0] CondG      = 4'd6;

  // Status codes
  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatAdr = 3'd2;
  localparam logic [2:0] StatIns = 3'd3;
  localparam logic [2:0] StatHlt = 3'd4;

  // Register ids
  localparam logic [3:0] RegRsp  = 4'd4;
  localparam logic [3:0] RegNone = 4'd15;

  // Bubble contents (ids are RegNone, values are zero)
  localparam logic [2:0] BubbleStat  = StatAok;
  localparam logic [3:0] BubbleIcode = IcodeNop;
  localparam logic [3:0] BubbleIfun  = 4'd0;

  // Reset value of the condition codes {ZF,SF,OF}
  localparam logic [2:0] CcReset = 3'b100;

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU with condition-flag generation.
//   aluA, aluB : operands (result = aluB op aluA)
//   aluFun     : AluAdd/AluSub/AluAnd/AluXor; other codes give 0
//   result     : modulo 2^DATA_W result
//   zf, sf, of : zero, sign and signed-overflow flags of result
module y86_alu
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0] aluA,
  input  logic [DATA_W-1:0] aluB,
  input  logic [3:0]        aluFun,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned Msb = DATA_W - 1;

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (aluFun)
      AluAdd: begin
        result = aluB + aluA;
        of     = (aluA[Msb] == aluB[Msb]) && (result[Msb] != aluA[Msb]);
      end
      AluSub: begin
        result = aluB - aluA;
        of     = (aluA[Msb] != aluB[Msb]) && (result[Msb] != aluB[Msb]);
      end
      AluAnd: result = aluB & aluA;
      AluXor: result = aluB ^ aluA;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[Msb];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, condition-code register, ALU
// operand selection and jXX/cmovXX condition evaluation.
//   clk, rst_n         : clock, asynchronous active-low reset
//   E_bubble           : load a bubble into E this edge
//   d_*                : decode outputs captured into E
//   m_stat, W_stat     : downstream status, gates CC updates
//   E_*                : registered E fields for hazard detection
//   e_Cnd/e_valE/e_valA/e_dstE : execute results to M register / forwarding
//   cc_out             : current {ZF,SF,OF}
module execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter logic [3:0]  RNONE  = RegNone
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              E_bubble,
  input  logic [2:0]        d_stat,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [DATA_W-1:0] d_valA,
  input  logic [DATA_W-1:0] d_valB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [3:0]        d_dstE,
  input  logic [3:0]        d_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic              e_Cnd,
  output logic [DATA_W-1:0] e_valE,
  output logic [DATA_W-1:0] e_valA,
  output logic [3:0]        e_dstE,
  output logic [2:0]        cc_out
);

  logic [DATA_W-1:0] E_valA, E_valB, E_valC;
  logic [3:0]        E_dstE;
  logic [2:0]        ccQ;
  logic [DATA_W-1:0] aluA, aluB;
  logic [3:0]        aluFun;
  logic              zf, sf, of, setCc;

  // E pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_stat  <= BubbleStat;
      E_icode <= BubbleIcode;
      E_ifun  <= BubbleIfun;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_valC  <= d_valC;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  // ALU operand and function selection
  always_comb begin
    aluA = '0;
    case (E_icode)
      IcodeRrmovq, IcodeOpq:                aluA = E_valA;
      IcodeIrmovq, IcodeRmmovq, IcodeMrmovq: aluA = E_valC;
      IcodeCall, IcodePushq:                aluA = ~DATA_W'(7);  // -8
      IcodeRet, IcodePopq:                  aluA = DATA_W'(8);
      default:                              aluA = '0;
    endcase
    aluB = '0;
    case (E_icode)
      IcodeRmmovq, IcodeMrmovq, IcodeOpq, IcodeCall,
      IcodePushq, IcodeRet, IcodePopq:      aluB = E_valB;
      default:                              aluB = '0;
    endcase
    aluFun = (E_icode == IcodeOpq) ? E_ifun : AluAdd;
  end

  y86_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .aluA   (aluA),
    .aluB   (aluB),
    .aluFun (aluFun),
    .result (e_valE),
    .zf     (zf),
    .sf     (sf),
    .of     (of)
  );

  // Only an OPQ with no exception further down the pipe may write CC
  assign setCc = (E_icode == IcodeOpq) && (m_stat == StatAok) && (W_stat == StatAok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccQ <= CcReset;
    end else if (setCc) begin
      ccQ <= {zf, sf, of};
    end
  end

  // Condition evaluated from the stored CC, not this cycle's flags
  always_comb begin
    logic ccZf, ccSf, ccOf, lt;
    ccZf  = ccQ[2];
    ccSf  = ccQ[1];
    ccOf  = ccQ[0];
    lt    = ccSf ^ ccOf;
    e_Cnd = 1'b0;
    case (E_ifun)
      CondAlways: e_Cnd = 1'b1;
      CondLe:     e_Cnd = lt | ccZf;
      CondL:      e_Cnd = lt;
      CondE:      e_Cnd = ccZf;
      CondNe:     e_Cnd = ~ccZf;
      CondGe:     e_Cnd = ~lt;
      CondG:      e_Cnd = ~lt & ~ccZf;
      default:    e_Cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes nothing
  assign e_dstE = ((E_icode == IcodeRrmovq) && !e_Cnd) ? RNONE : E_dstE;
  assign e_valA = E_valA;
  assign cc_out = ccQ;

endmodule
